// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame constants for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int WORD_BYTES           = 4;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - two-flop synchronizer with parameterized reset value
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver assembling little-endian 32-bit words
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int GAP_BITS     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_line,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        word_drop
);

  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);

  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_M1    = GW'(GAP_LIMIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(WORD_BYTES - 1);

  state_t          r_state;
  state_t          w_next;
  logic            w_rxs;
  logic [1:0]      r_settle;
  logic            w_settled;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_word_acc;
  logic [GW-1:0]   r_gap_cnt;
  logic [7:0]      r_byte_out;
  logic            r_byte_valid;
  logic [31:0]     r_data_out;
  logic            r_data_valid;
  logic            r_frame_err;
  logic            r_word_drop;

  logic            w_tick;
  logic            w_start_det;
  logic            w_accept;
  logic            w_bad_stop;
  logic            w_gap_hit;

  bit_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_line),
    .q   (w_rxs)
  );

  // rxs only reflects the real line once ones have shifted through both sync flops
  assign w_settled = r_settle[1];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_settled)  w_next = ST_WAIT_HIGH;
        else if (!w_rxs) w_next = ST_START;
      end
      ST_START: if (w_tick) w_next = w_rxs ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_tick && r_bit_idx == LAST_BIT) w_next = ST_STOP;
      ST_STOP:  if (w_tick) w_next = w_rxs ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (w_settled && w_rxs) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      ST_START:         w_tick = (r_clk_cnt == HALF_M1);
      ST_DATA, ST_STOP: w_tick = (r_clk_cnt == FULL_M1);
      default:          w_tick = 1'b0;
    endcase
    w_start_det = (r_state == ST_IDLE) && w_settled && !w_rxs;
    w_accept    = (r_state == ST_STOP) && w_tick && w_rxs;
    w_bad_stop  = (r_state == ST_STOP) && w_tick && !w_rxs;
    w_gap_hit   = (r_state == ST_IDLE) && !w_start_det &&
                  (r_byte_cnt != 2'd0) && (r_gap_cnt == GAP_M1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle     <= 2'b00;
      r_clk_cnt    <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'd0;
      r_byte_cnt   <= 2'd0;
      r_word_acc   <= 24'd0;
      r_gap_cnt    <= '0;
      r_byte_out   <= 8'd0;
      r_byte_valid <= 1'b0;
      r_data_out   <= 32'd0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_word_drop  <= 1'b0;
    end else begin
      r_settle     <= {r_settle[0], 1'b1};
      r_byte_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_word_drop  <= 1'b0;

      if (w_tick || r_state != w_next || r_state == ST_IDLE || r_state == ST_WAIT_HIGH)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + CW'(1);

      if (w_start_det) r_bit_idx <= 3'd0;

      if (r_state == ST_DATA && w_tick) begin
        r_shift   <= {w_rxs, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (w_accept) begin
        r_byte_out   <= r_shift;
        r_byte_valid <= 1'b1;
        case (r_byte_cnt)
          2'd0:    r_word_acc[7:0]   <= r_shift;
          2'd1:    r_word_acc[15:8]  <= r_shift;
          2'd2:    r_word_acc[23:16] <= r_shift;
          default: begin
            r_data_out   <= {r_shift, r_word_acc};
            r_data_valid <= 1'b1;
          end
        endcase
        r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? 2'd0 : r_byte_cnt + 2'd1;
      end

      // a bad stop bit silently abandons whatever part of the word was collected
      if (w_bad_stop) begin
        r_frame_err <= 1'b1;
        r_byte_cnt  <= 2'd0;
      end

      if (w_gap_hit) begin
        r_byte_cnt  <= 2'd0;
        r_word_drop <= 1'b1;
        r_gap_cnt   <= '0;
      end else if (r_state == ST_IDLE && !w_start_det && r_byte_cnt != 2'd0) begin
        r_gap_cnt <= r_gap_cnt + GW'(1);
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign word_drop  = r_word_drop;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (100 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have parameter GAP_BITS, default 20, meaning the idle bit-times between bytes after which a partial word is dropped.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx_line  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port byte_out  output  8  last received byte.
REQ-007 SHALL have port byte_valid  output  1  one-cycle pulse, byte_out valid.
REQ-008 SHALL have port data_out  output  32  assembled word.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse, data_out valid; no backpressure.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port word_drop  output  1  one-cycle pulse when a partial word is discarded.

Function
REQ-012 SHALL pass rx_line through a 2-flop synchronizer; all decoding uses the synchronized signal (rxs).
REQ-013 SHALL decode 8N1 frames: start bit low, 8 data bits LSB first, one stop bit high, no parity.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: on rxs==0, go to START with the bit counter cleared.
REQ-016 START: after CLKS_PER_BIT/2 cycles (integer divide), sample rxs; 0 -> DATA; 1 -> IDLE (false start, no output, no error).
REQ-017 DATA: sample rxs every CLKS_PER_BIT cycles at mid-bit, shifting into bit index 0..7; after bit 7 go to STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles sample rxs; 1 -> IDLE and accept byte; 0 -> frame_err, discard byte and any partial word (no word_drop pulse), go to WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rxs==1, then IDLE; a low line (break) SHALL never produce bytes.
REQ-020 Accepted byte: byte_out updated and byte_valid pulsed in the cycle after the stop sample; byte_out holds until the next accepted byte.
REQ-021 Word assembly: byte k (k=0..3) SHALL go to data_out[8k+7:8k] (little-endian, matching uart_tx serialization of decision_data); byte counter wraps 3->0.
REQ-022 On the 4th byte, data_valid SHALL pulse in the same cycle as that byte_valid, with data_out complete; data_out holds until the next word completes.
REQ-023 Gap timer: while byte counter !=0 and state==IDLE, count cycles; at GAP_BITS*CLKS_PER_BIT clear byte counter and pulse word_drop once; timer clears on any start detection.
REQ-024 Bit-period counter SHALL be wide enough for CLKS_PER_BIT-1; gap counter wide enough for GAP_BITS*CLKS_PER_BIT without overflow.
REQ-025 Back-to-back frames (start bit immediately after stop sample) SHALL be received without loss.

Reset
REQ-026 On rst: state IDLE, synchronizer flops 1, counters 0, byte counter 0, byte_out 0, data_out 0, all pulse outputs 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame and partial word with no byte_valid, data_valid, frame_err or word_drop.
REQ-028 After reset release, a line already low SHALL be treated as a start edge only once rxs has been observed high (enter WAIT_HIGH on release).

Structure
REQ-029 Shared package uart_pkg SHALL hold the state enum, default CLKS_PER_BIT, WORD_BYTES=4 and frame constants (DATA_BITS=8).
REQ-030 The 2-flop synchronizer SHALL be a sub-module named bit_sync (reset value parameterized, here 1).

Verification (bench runs CLKS_PER_BIT=16, GAP_BITS=4)
REQ-031 Send bytes 0x78,0x56,0x34,0x12 back-to-back -> four byte_valid pulses, one data_valid with data_out=0x12345678.
REQ-032 Drive 0x55 with stop bit low -> frame_err one pulse, no byte_valid; hold line low 50 bit-times -> no output until line high.
REQ-033 Low glitch of 5 clocks on idle line -> no outputs, state back to IDLE.
REQ-034 Send 0xAA,0xBB, then idle 5 bit-times -> word_drop one pulse; then 0x01,0x02,0x03,0x04 -> data_out=0x04030201.
REQ-035 Assert rst at data bit 4 of the 3rd byte -> all outputs 0; subsequent 4-byte word 0xDEADBEEF (sent EF,BE,AD,DE) decoded correctly.
REQ-036 Bit timing skew of +/-3% on sent frames -> same results as REQ-031.
